dt_param: RTL and testbench

DT_PARAM -- requirements
Module: dt_param

---
 rtl/dt_param.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_dt_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dt_param.sv
// Two-pass distance transform (chessboard or city-block) of a binary image.
// The image is streamed in from a word memory and processed in place in a pixel result memory.
module dt_param #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int STI_W  = 16,
    parameter int DIST_W = 8,
    localparam int SA    = $clog2(IMG_W * IMG_H / STI_W),
    localparam int RA    = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              metric,
    output logic              sti_rd,
    output logic [SA-1:0]     sti_addr,
    input  logic [STI_W-1:0]  sti_di,
    output logic              res_rd,
    output logic              res_wr,
    output logic [RA-1:0]     res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di,
    output logic              fwpass_finish,
    output logic              done
);

    localparam int NWORDS = IMG_W * IMG_H / STI_W;
    localparam int RW     = $clog2(IMG_H);
    localparam int CW     = $clog2(IMG_W);
    localparam int BW     = (STI_W > 1) ? $clog2(STI_W) : 1;

    localparam logic [2:0] LD_RD   = 3'd0;
    localparam logic [2:0] LD_DATA = 3'd1;
    localparam logic [2:0] LD_WR   = 3'd2;
    localparam logic [2:0] PX_RD4  = 3'd4;
    localparam logic [2:0] PX_WAIT = 3'd5;
    localparam logic [2:0] PX_WR   = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FWD, S_BWD, S_FIN} state_t;

    state_t              state_r, state_nxt_s;
    logic [2:0]          step_r, step_nxt_s;
    logic [BW-1:0]       bit_r, bit_nxt_s;
    logic [RA-1:0]       pix_r, pix_nxt_s;
    logic [RW-1:0]       row_r, row_nxt_s, nrow_s;
    logic [CW-1:0]       col_r, col_nxt_s, ncol_s;
    logic [STI_W-1:0]    buf_r, buf_nxt_s;
    logic                metric_r, metric_nxt_s;
    logic [DIST_W-1:0]   op0_r, op1_r, op2_r, op3_r;
    logic                sti_rd_r, sti_rd_nxt_s;
    logic [SA-1:0]       sti_addr_r, sti_addr_nxt_s;
    logic                res_rd_r, res_rd_nxt_s;
    logic                res_wr_r, res_wr_nxt_s;
    logic [RA-1:0]       res_addr_r, res_addr_nxt_s;
    logic [DIST_W-1:0]   res_do_r, res_do_nxt_s;
    logic                fwp_r, fwp_nxt_s;
    logic                done_r, done_nxt_s;
    logic                px_active_s, last_px_s, word_last_s, bit_last_s;
    logic [RA-1:0]       center_s;
    logic [DIST_W-1:0]   nb_min_s, cand_s, wr_val_s;

    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        sat_inc = (v == {DIST_W{1'b1}}) ? v : v + DIST_W'(1);
    endfunction

    function automatic logic [DIST_W-1:0] min2(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
        min2 = (a < b) ? a : b;
    endfunction

    function automatic logic [RA-1:0] pix_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        pix_addr = RA'(r) * RA'(IMG_W) + RA'(c);
    endfunction

    // Read order: forward = C, NW, N, NE, W; backward = C, E, SW, S, SE.
    function automatic logic [RA-1:0] nb_addr(input logic [RA-1:0] c, input logic bwd, input logic [2:0] idx);
        logic [RA-1:0] wa;
        wa = RA'(IMG_W);
        case (idx)
            3'd1:    nb_addr = bwd ? c + RA'(1)      : c - wa - RA'(1);
            3'd2:    nb_addr = bwd ? c + wa - RA'(1) : c - wa;
            3'd3:    nb_addr = bwd ? c + wa          : c - wa + RA'(1);
            3'd4:    nb_addr = bwd ? c + wa + RA'(1) : c - RA'(1);
            default: nb_addr = c;
        endcase
    endfunction

    assign px_active_s = (state_r == S_FWD) || (state_r == S_BWD);
    assign word_last_s = (sti_addr_r == SA'(NWORDS - 1));
    assign bit_last_s  = (bit_r == BW'(STI_W - 1));
    assign center_s    = pix_addr(row_r, col_r);

    // Next interior pixel in raster (forward) or reverse raster (backward) order.
    always_comb begin
        nrow_s    = row_r;
        ncol_s    = col_r;
        last_px_s = 1'b0;
        if (state_r == S_BWD) begin
            last_px_s = (row_r == RW'(1)) && (col_r == CW'(1));
            if (col_r == CW'(1)) begin
                ncol_s = CW'(IMG_W - 2);
                nrow_s = row_r - RW'(1);
            end else begin
                ncol_s = col_r - CW'(1);
            end
        end else begin
            last_px_s = (row_r == RW'(IMG_H - 2)) && (col_r == CW'(IMG_W - 2));
            if (col_r == CW'(IMG_W - 2)) begin
                ncol_s = CW'(1);
                nrow_s = row_r + RW'(1);
            end else begin
                ncol_s = col_r + CW'(1);
            end
        end
    end

    // Distance to write for the current pixel; the last neighbour arrives straight from res_di.
    always_comb begin
        nb_min_s = {DIST_W{1'b0}};
        cand_s   = {DIST_W{1'b0}};
        if (state_r == S_BWD) begin
            if (metric_r) begin
                nb_min_s = min2(op1_r, op3_r);
            end else begin
                nb_min_s = min2(min2(op1_r, op2_r), min2(op3_r, res_di));
            end
            cand_s = min2(op0_r, sat_inc(nb_min_s));
        end else begin
            if (metric_r) begin
                nb_min_s = min2(op2_r, res_di);
            end else begin
                nb_min_s = min2(min2(op1_r, op2_r), min2(op3_r, res_di));
            end
            cand_s = sat_inc(nb_min_s);
        end
        wr_val_s = (op0_r == {DIST_W{1'b0}}) ? {DIST_W{1'b0}} : cand_s;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  state_nxt_s = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt_s = ((step_r == LD_WR) && bit_last_s && word_last_s) ? S_FWD : S_LOAD;
            S_FWD:   state_nxt_s = ((step_r == PX_WR) && last_px_s) ? S_BWD : S_FWD;
            S_BWD:   state_nxt_s = ((step_r == PX_WR) && last_px_s) ? S_FIN : S_BWD;
            S_FIN:   state_nxt_s = start ? S_LOAD : S_FIN;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output and datapath sequencing: computes what is presented to the memories next cycle.
    always_comb begin
        sti_rd_nxt_s   = 1'b0;
        res_rd_nxt_s   = 1'b0;
        res_wr_nxt_s   = 1'b0;
        sti_addr_nxt_s = sti_addr_r;
        res_addr_nxt_s = res_addr_r;
        res_do_nxt_s   = res_do_r;
        fwp_nxt_s      = fwp_r;
        done_nxt_s     = done_r;
        step_nxt_s     = step_r;
        bit_nxt_s      = bit_r;
        pix_nxt_s      = pix_r;
        row_nxt_s      = row_r;
        col_nxt_s      = col_r;
        buf_nxt_s      = buf_r;
        metric_nxt_s   = metric_r;
        case (state_r)
            S_IDLE, S_FIN: begin
                if (start) begin
                    metric_nxt_s   = metric;
                    fwp_nxt_s      = 1'b0;
                    done_nxt_s     = 1'b0;
                    sti_rd_nxt_s   = 1'b1;
                    sti_addr_nxt_s = {SA{1'b0}};
                    step_nxt_s     = LD_RD;
                    pix_nxt_s      = {RA{1'b0}};
                end else begin
                    step_nxt_s = step_r;
                end
            end
            S_LOAD: begin
                case (step_r)
                    LD_RD: step_nxt_s = LD_DATA;
                    LD_DATA: begin
                        buf_nxt_s      = sti_di << 1;
                        res_wr_nxt_s   = 1'b1;
                        res_do_nxt_s   = DIST_W'(sti_di[STI_W-1]);
                        res_addr_nxt_s = pix_r;
                        pix_nxt_s      = pix_r + RA'(1);
                        bit_nxt_s      = {BW{1'b0}};
                        step_nxt_s     = LD_WR;
                    end
                    LD_WR: begin
                        if (!bit_last_s) begin
                            buf_nxt_s      = buf_r << 1;
                            res_wr_nxt_s   = 1'b1;
                            res_do_nxt_s   = DIST_W'(buf_r[STI_W-1]);
                            res_addr_nxt_s = pix_r;
                            pix_nxt_s      = pix_r + RA'(1);
                            bit_nxt_s      = bit_r + BW'(1);
                        end else if (word_last_s) begin
                            row_nxt_s      = RW'(1);
                            col_nxt_s      = CW'(1);
                            res_rd_nxt_s   = 1'b1;
                            res_addr_nxt_s = pix_addr(RW'(1), CW'(1));
                            step_nxt_s     = 3'd0;
                        end else begin
                            sti_rd_nxt_s   = 1'b1;
                            sti_addr_nxt_s = sti_addr_r + SA'(1);
                            step_nxt_s     = LD_RD;
                        end
                    end
                    default: step_nxt_s = LD_RD;
                endcase
            end
            S_FWD, S_BWD: begin
                case (step_r)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        res_rd_nxt_s   = 1'b1;
                        res_addr_nxt_s = nb_addr(center_s, state_r == S_BWD, step_r + 3'd1);
                        step_nxt_s     = step_r + 3'd1;
                    end
                    PX_RD4: step_nxt_s = PX_WAIT;
                    PX_WAIT: begin
                        res_wr_nxt_s   = 1'b1;
                        res_do_nxt_s   = wr_val_s;
                        res_addr_nxt_s = center_s;
                        step_nxt_s     = PX_WR;
                    end
                    PX_WR: begin
                        step_nxt_s = 3'd0;
                        if (!last_px_s) begin
                            row_nxt_s      = nrow_s;
                            col_nxt_s      = ncol_s;
                            res_rd_nxt_s   = 1'b1;
                            res_addr_nxt_s = pix_addr(nrow_s, ncol_s);
                        end else if (state_r == S_FWD) begin
                            fwp_nxt_s      = 1'b1;
                            row_nxt_s      = RW'(IMG_H - 2);
                            col_nxt_s      = CW'(IMG_W - 2);
                            res_rd_nxt_s   = 1'b1;
                            res_addr_nxt_s = pix_addr(RW'(IMG_H - 2), CW'(IMG_W - 2));
                        end else begin
                            done_nxt_s = 1'b1;
                        end
                    end
                    default: step_nxt_s = 3'd0;
                endcase
            end
            default: step_nxt_s = 3'd0;
        endcase
    end

    // Datapath and output registers; neighbour reads are captured one cycle after issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_r     <= 3'd0;
            bit_r      <= {BW{1'b0}};
            pix_r      <= {RA{1'b0}};
            row_r      <= {RW{1'b0}};
            col_r      <= {CW{1'b0}};
            buf_r      <= {STI_W{1'b0}};
            metric_r   <= 1'b0;
            op0_r      <= {DIST_W{1'b0}};
            op1_r      <= {DIST_W{1'b0}};
            op2_r      <= {DIST_W{1'b0}};
            op3_r      <= {DIST_W{1'b0}};
            sti_rd_r   <= 1'b0;
            sti_addr_r <= {SA{1'b0}};
            res_rd_r   <= 1'b0;
            res_wr_r   <= 1'b0;
            res_addr_r <= {RA{1'b0}};
            res_do_r   <= {DIST_W{1'b0}};
            fwp_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            step_r     <= step_nxt_s;
            bit_r      <= bit_nxt_s;
            pix_r      <= pix_nxt_s;
            row_r      <= row_nxt_s;
            col_r      <= col_nxt_s;
            buf_r      <= buf_nxt_s;
            metric_r   <= metric_nxt_s;
            sti_rd_r   <= sti_rd_nxt_s;
            sti_addr_r <= sti_addr_nxt_s;
            res_rd_r   <= res_rd_nxt_s;
            res_wr_r   <= res_wr_nxt_s;
            res_addr_r <= res_addr_nxt_s;
            res_do_r   <= res_do_nxt_s;
            fwp_r      <= fwp_nxt_s;
            done_r     <= done_nxt_s;
            if (px_active_s) begin
                case (step_r)
                    3'd1:    op0_r <= res_di;
                    3'd2:    op1_r <= res_di;
                    3'd3:    op2_r <= res_di;
                    3'd4:    op3_r <= res_di;
                    default: op0_r <= op0_r;
                endcase
            end
        end
    end

    assign sti_rd        = sti_rd_r;
    assign sti_addr      = sti_addr_r;
    assign res_rd        = res_rd_r;
    assign res_wr        = res_wr_r;
    assign res_addr      = res_addr_r;
    assign res_do        = res_do_r;
    assign fwpass_finish = fwp_r;
    assign done          = done_r;

endmodule

// File: tb/tb_dt_param.sv
// Directed bench for dt_param: a 16x8 instance (8-bit distances) and a 16x16 instance
// (2-bit distances), each with behavioural source and result memories.
module tb_dt_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        reset_a, start_a, metric_a;
    logic        sti_rd_a, res_rd_a, res_wr_a, fwp_a, done_a;
    logic [2:0]  sti_addr_a;
    logic [15:0] sti_di_a;
    logic [6:0]  res_addr_a;
    logic [7:0]  res_do_a, res_di_a;
    logic [15:0] sti_mem_a [8];
    logic [7:0]  res_mem_a [128];

    logic        reset_b, start_b, metric_b;
    logic        sti_rd_b, res_rd_b, res_wr_b, fwp_b, done_b;
    logic [3:0]  sti_addr_b;
    logic [15:0] sti_di_b;
    logic [7:0]  res_addr_b;
    logic [1:0]  res_do_b, res_di_b;
    logic [15:0] sti_mem_b [16];
    logic [1:0]  res_mem_b [256];

    logic clr = 1'b0;
    int sti_cnt_a = 0, wr_lo_a = 0, wr_hi_a = 0, sti_cnt_b = 0;
    int overlap = 0, stray_sti = 0;

    dt_param #(.IMG_W(16), .IMG_H(8), .STI_W(16), .DIST_W(8)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .metric(metric_a),
        .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
        .res_rd(res_rd_a), .res_wr(res_wr_a), .res_addr(res_addr_a),
        .res_do(res_do_a), .res_di(res_di_a),
        .fwpass_finish(fwp_a), .done(done_a)
    );

    dt_param #(.IMG_W(16), .IMG_H(16), .STI_W(16), .DIST_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .metric(metric_b),
        .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
        .res_rd(res_rd_b), .res_wr(res_wr_b), .res_addr(res_addr_b),
        .res_do(res_do_b), .res_di(res_di_b),
        .fwpass_finish(fwp_b), .done(done_b)
    );

    // Memories: read data one cycle after the strobe, writes land on the edge.
    always @(posedge clk) begin
        if (sti_rd_a) sti_di_a <= sti_mem_a[sti_addr_a];
        if (res_rd_a) res_di_a <= res_mem_a[res_addr_a];
        if (res_wr_a) res_mem_a[res_addr_a] <= res_do_a;
        if (sti_rd_b) sti_di_b <= sti_mem_b[sti_addr_b];
        if (res_rd_b) res_di_b <= res_mem_b[res_addr_b];
        if (res_wr_b) res_mem_b[res_addr_b] <= res_do_b;
    end

    // Strobe counters per run, plus run-wide protocol violations.
    always @(posedge clk) begin
        if (clr) begin
            sti_cnt_a <= 0; wr_lo_a <= 0; wr_hi_a <= 0; sti_cnt_b <= 0;
        end else begin
            if (sti_rd_a) sti_cnt_a <= sti_cnt_a + 1;
            if (res_wr_a && !fwp_a) wr_lo_a <= wr_lo_a + 1;
            if (res_wr_a && fwp_a && !done_a) wr_hi_a <= wr_hi_a + 1;
            if (sti_rd_b) sti_cnt_b <= sti_cnt_b + 1;
        end
        if ((res_rd_a && res_wr_a) || (res_rd_b && res_wr_b)) overlap <= overlap + 1;
        if ((sti_rd_a && fwp_a) || (sti_rd_b && fwp_b)) stray_sti <= stray_sti + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pa(input int r, input int c);
        return int'(res_mem_a[r * 16 + c]);
    endfunction

    function automatic int pb(input int r, input int c);
        return int'(res_mem_b[r * 16 + c]);
    endfunction

    task automatic fill_a(input logic [15:0] w);
        for (int i = 0; i < 8; i++) sti_mem_a[i] = w;
    endtask

    // Accepted start: next cycle shows the first source read at word 0 and done cleared.
    task automatic kick_a(input logic m);
        @(negedge clk);
        metric_a = m; start_a = 1'b1; clr = 1'b1;
        @(negedge clk);
        start_a = 1'b0; clr = 1'b0;
        check("start_sti_rd", int'(sti_rd_a), 1);
        check("start_sti_addr", int'(sti_addr_a), 0);
        check("start_done_low", int'(done_a), 0);
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(done_a), 1);
    endtask

    initial begin
        int zeros, nonzero, quiet;
        reset_a = 1'b1; start_a = 1'b0; metric_a = 1'b0;
        reset_b = 1'b1; start_b = 1'b0; metric_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);
        check("rst_strobes", int'({sti_rd_a, res_rd_a, res_wr_a}), 0);
        check("rst_flags", int'({done_a, fwp_a}), 0);
        check("rst_addrs", int'(sti_addr_a) + int'(res_addr_a) + int'(res_do_a), 0);

        // All ones, chessboard: distance to the virtual frame outside the image.
        fill_a(16'hFFFF);
        kick_a(1'b0);
        wait_done_a("done_ones_m0");
        check("ones_fwp_high", int'(fwp_a), 1);
        check("ones_sti_words", sti_cnt_a, 8);
        check("ones_p4_8", pa(4, 8), 4);
        check("ones_p1_1", pa(1, 1), 2);
        check("ones_p3_3", pa(3, 3), 4);
        check("ones_p6_14", pa(6, 14), 2);
        check("ones_border_0_0", pa(0, 0), 1);
        check("ones_border_7_15", pa(7, 15), 1);

        // Single zero at (4,8), chessboard; a start during the backward pass must be ignored.
        sti_mem_a[4] = 16'hFF7F;
        kick_a(1'b0);
        begin
            int n = 0;
            while (!fwp_a && n < 2000) begin @(negedge clk); n++; end
            check("fwp_reached", int'(fwp_a), 1);
        end
        repeat (20) @(negedge clk);
        metric_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("bwd_start_ignored", int'(sti_rd_a), 0);
        wait_done_a("done_zero_m0");
        check("bwd_start_sti_words", sti_cnt_a, 8);
        check("zero_m0_p3_9", pa(3, 9), 1);
        check("zero_m0_p5_10", pa(5, 10), 2);
        check("zero_m0_p4_8", pa(4, 8), 0);

        // Restart from FIN with city-block metric.
        kick_a(1'b1);
        wait_done_a("done_zero_m1");
        check("zero_m1_p3_9", pa(3, 9), 2);
        check("zero_m1_p5_10", pa(5, 10), 3);
        check("zero_m1_p4_11", pa(4, 11), 3);
        check("zero_m1_p4_6", pa(4, 6), 2);
        check("zero_m1_p4_9", pa(4, 9), 1);

        // All-zero image: every pixel 0, 84 interior writes per pass.
        fill_a(16'h0000);
        kick_a(1'b1);
        wait_done_a("done_allzero");
        nonzero = 0;
        for (int i = 0; i < 128; i++) if (res_mem_a[i] != 8'd0) nonzero++;
        check("allzero_nonzero", nonzero, 0);
        check("allzero_load_fwd_writes", wr_lo_a, 128 + 84);
        check("allzero_bwd_writes", wr_hi_a, 84);

        // Reset during the forward pass aborts; rerun starts again from word 0.
        fill_a(16'hFFFF);
        kick_a(1'b0);
        begin
            int n = 0;
            while (wr_lo_a < 150 && n < 2000) begin @(negedge clk); n++; end
            check("reach_fwd", int'(wr_lo_a >= 150), 1);
        end
        reset_a = 1'b1;
        @(negedge clk);
        check("abort_strobes", int'({sti_rd_a, res_rd_a, res_wr_a}), 0);
        check("abort_flags", int'({done_a, fwp_a}), 0);
        @(negedge clk);
        reset_a = 1'b0;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sti_rd_a || res_rd_a || res_wr_a) quiet++;
        end
        check("idle_after_reset", quiet, 0);
        kick_a(1'b0);
        wait_done_a("done_rerun");
        check("rerun_p4_8", pa(4, 8), 4);
        check("rerun_sti_words", sti_cnt_a, 8);

        // 2-bit distances saturate at 3 and never wrap to 0.
        for (int i = 0; i < 16; i++) sti_mem_b[i] = 16'hFFFF;
        @(negedge clk);
        metric_b = 1'b0; start_b = 1'b1; clr = 1'b1;
        @(negedge clk);
        start_b = 1'b0; clr = 1'b0;
        begin
            int n = 0;
            while (!done_b && n < 6000) begin @(negedge clk); n++; end
            check("done_b", int'(done_b), 1);
        end
        check("sat_sti_words", sti_cnt_b, 16);
        check("sat_p7_7", pb(7, 7), 3);
        check("sat_p8_8", pb(8, 8), 3);
        check("sat_p2_2", pb(2, 2), 3);
        check("sat_p1_5", pb(1, 5), 2);
        zeros = 0;
        for (int i = 0; i < 256; i++) if (res_mem_b[i] == 2'd0) zeros++;
        check("sat_no_zero", zeros, 0);

        check("rd_wr_overlap", overlap, 0);
        check("sti_rd_outside_load", stray_sti, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
